// File: rtl/keypad_key_fifo_if.sv
// Key FIFO bus: controller write side, APB pop side and status.
// Master drives strobes/threshold; slave (the FIFO) returns head and status.
interface keypad_key_fifo_if #(
    parameter int LEVEL_WIDTH = 5
);
    logic                   wr_en_i;
    logic [5:0]             wr_position_i;
    logic [7:0]             wr_ascii_i;
    logic                   rd_en_i;
    logic                   fifo_clear_i;
    logic                   overflow_clr_i;
    logic [LEVEL_WIDTH-1:0] threshold_i;
    logic [5:0]             rd_position_o;
    logic [7:0]             rd_ascii_o;
    logic                   rd_valid_o;
    logic                   position_fifo_full_o;
    logic                   keycode_fifo_full_o;
    logic                   empty_o;
    logic [LEVEL_WIDTH-1:0] level_o;
    logic                   threshold_irq_o;
    logic                   overflow_o;
    logic                   underflow_o;
    logic [7:0]             drop_count_o;

    modport master (
        output wr_en_i, wr_position_i, wr_ascii_i,
        output rd_en_i, fifo_clear_i, overflow_clr_i,
        output threshold_i,
        input  rd_position_o, rd_ascii_o, rd_valid_o,
        input  position_fifo_full_o, keycode_fifo_full_o,
        input  empty_o, level_o, threshold_irq_o,
        input  overflow_o, underflow_o, drop_count_o
    );

    modport slave (
        input  wr_en_i, wr_position_i, wr_ascii_i,
        input  rd_en_i, fifo_clear_i, overflow_clr_i,
        input  threshold_i,
        output rd_position_o, rd_ascii_o, rd_valid_o,
        output position_fifo_full_o, keycode_fifo_full_o,
        output empty_o, level_o, threshold_irq_o,
        output overflow_o, underflow_o, drop_count_o
    );
endinterface

// File: rtl/keypad_key_fifo.sv
// FWFT key event FIFO between keypad scanner and APB slave.
// Optional KEYPAD_FIFO_DROP_CNT_EN adds a saturating dropped-write counter.
module keypad_key_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int LEVEL_WIDTH = DEPTH_LOG2 + 1
) (
    input  logic             system_clk_i,
    input  logic             system_rst_n_i,
    keypad_key_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [LEVEL_WIDTH-1:0] FULL_LVL = LEVEL_WIDTH'(DEPTH);

    logic [13:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic irq_q, irq_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
    logic wr_ok, rd_ok, ovf_evt, udf_evt;
    logic clr;

    assign clr = bus.fifo_clear_i;

    // Accept/reject decisions, pointer and level update, status flags
    always_comb begin
        wr_ok    = bus.wr_en_i & ~full_q & ~clr;
        rd_ok    = bus.rd_en_i & ~empty_q & ~clr;
        ovf_evt  = bus.wr_en_i & full_q & ~clr;
        udf_evt  = bus.rd_en_i & empty_q & ~clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        full_d  = (level_d == FULL_LVL);
        empty_d = (level_d == '0);
        irq_d   = (bus.threshold_i != '0) &&
                  (level_d >= bus.threshold_i);
        ovf_d   = ovf_evt | (ovf_q & ~bus.overflow_clr_i);
        udf_d   = udf_evt | (udf_q & ~bus.overflow_clr_i);
    end

    // Control and status registers
    always_ff @(posedge system_clk_i) begin
        if (!system_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Entry storage; contents are never reset
    always_ff @(posedge system_clk_i) begin
        if (system_rst_n_i && wr_ok)
            mem_q[wr_ptr_q] <= {bus.wr_position_i, bus.wr_ascii_i};
    end

    assign bus.rd_position_o        = mem_q[rd_ptr_q][13:8];
    assign bus.rd_ascii_o           = mem_q[rd_ptr_q][7:0];
    assign bus.rd_valid_o           = ~empty_q;
    assign bus.position_fifo_full_o = full_q;
    assign bus.keycode_fifo_full_o  = full_q;
    assign bus.empty_o              = empty_q;
    assign bus.level_o              = level_q;
    assign bus.threshold_irq_o      = irq_q;
    assign bus.overflow_o           = ovf_q;
    assign bus.underflow_o          = udf_q;

`ifdef KEYPAD_FIFO_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Saturating count of rejected writes; a drop beats a same-cycle clear
    always_comb begin
        drop_d = drop_q;
        if (ovf_evt) begin
            if (bus.overflow_clr_i)   drop_d = 8'd1;
            else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (bus.overflow_clr_i) begin
            drop_d = '0;
        end
    end

    // Drop counter register
    always_ff @(posedge system_clk_i) begin
        if (!system_rst_n_i) drop_q <= '0;
        else                 drop_q <= drop_d;
    end

    assign bus.drop_count_o = drop_q;
`else
    assign bus.drop_count_o = '0;
`endif
endmodule

// File: tb/tb_keypad_key_fifo.sv
// Self-checking bench for keypad_key_fifo.
// Directed scenarios plus randomized traffic against a queue model.
module tb_keypad_key_fifo;
    localparam int DL    = 4;
    localparam int LW    = DL + 1;
    localparam int DEPTH = 16;
`ifdef KEYPAD_FIFO_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    keypad_key_fifo_if #(.LEVEL_WIDTH(LW)) bus ();

    keypad_key_fifo #(.DEPTH_LOG2(DL), .LEVEL_WIDTH(LW)) dut (
        .system_clk_i   (clk),
        .system_rst_n_i (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0]   mq[$];
    bit            m_ovf, m_udf, m_irq;
    int            m_drop;
    logic [LW-1:0] thr;

    function automatic int exp_drop();
        return DROP_EN ? m_drop : 0;
    endfunction

    task automatic idle_inputs();
        bus.wr_en_i        = 1'b0;
        bus.wr_position_i  = '0;
        bus.wr_ascii_i     = '0;
        bus.rd_en_i        = 1'b0;
        bus.fifo_clear_i   = 1'b0;
        bus.overflow_clr_i = 1'b0;
    endtask

    // Drive one clock of stimulus and advance the reference model
    task automatic cycle(input bit rn, input bit w, input logic [5:0] p,
                         input logic [7:0] a, input bit r, input bit c,
                         input bit oc);
        bit full, empty, oe, ue;
        rst_n              = rn;
        bus.wr_en_i        = w;
        bus.wr_position_i  = p;
        bus.wr_ascii_i     = a;
        bus.rd_en_i        = r;
        bus.fifo_clear_i   = c;
        bus.overflow_clr_i = oc;
        bus.threshold_i    = thr;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_drop = 0; m_irq = 0;
        end else begin
            oe = 0; ue = 0;
            if (c) begin
                mq.delete();
            end else begin
                full  = (mq.size() == DEPTH);
                empty = (mq.size() == 0);
                oe = w && full;
                ue = r && empty;
                if (r && !empty) void'(mq.pop_front());
                if (w && !full) mq.push_back({p, a});
            end
            m_ovf = oe || (m_ovf && !oc);
            m_udf = ue || (m_udf && !oc);
            if (oe) m_drop = oc ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            else if (oc) m_drop = 0;
            m_irq = (thr != 0) && (mq.size() >= int'(thr));
        end
        #1;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset();
        thr = '0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.level_o, bus.empty_o, bus.rd_valid_o,
             bus.position_fifo_full_o, bus.keycode_fifo_full_o,
             bus.threshold_irq_o, bus.overflow_o, bus.underflow_o,
             bus.drop_count_o} !== {5'd0, 1'b1, 1'b0, 4'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset: lvl=%0d emp=%b val=%b ovf=%b udf=%b drop=%0d want 0/1/0/0/0/0",
                     bus.level_o, bus.empty_o, bus.rd_valid_o,
                     bus.overflow_o, bus.underflow_o, bus.drop_count_o);
        end
    endtask

    task automatic test_first_write();
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 6'o12, 8'h57, 0, 0, 0);
        n_cmp++;
        if ({bus.rd_valid_o, bus.rd_position_o, bus.rd_ascii_o,
             bus.level_o, bus.empty_o} !== {1'b1, 6'o12, 8'h57, 5'd1, 1'b0}) begin
            n_err++;
            $display("FAIL first_write: val=%b pos=%o asc=%h lvl=%0d emp=%b want 1/12/57/1/0",
                     bus.rd_valid_o, bus.rd_position_o, bus.rd_ascii_o,
                     bus.level_o, bus.empty_o);
        end
    endtask

    task automatic test_fill_overflow();
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            cycle(1, 1, 6'(i), 8'(8'h30 + i), 0, 0, 0);
        n_cmp++;
        if ({bus.position_fifo_full_o, bus.keycode_fifo_full_o, bus.level_o}
            !== {2'b11, 5'd16}) begin
            n_err++;
            $display("FAIL fill_full: full=%b/%b lvl=%0d want 1/1/16",
                     bus.position_fifo_full_o, bus.keycode_fifo_full_o, bus.level_o);
        end
        cycle(1, 1, 6'o77, 8'hEE, 0, 0, 0);
        n_cmp++;
        if ({bus.overflow_o, bus.level_o} !== {1'b1, 5'd16} ||
            int'(bus.drop_count_o) != (DROP_EN ? 1 : 0)) begin
            n_err++;
            $display("FAIL overflow: ovf=%b lvl=%0d drop=%0d want 1/16/%0d",
                     bus.overflow_o, bus.level_o, bus.drop_count_o, DROP_EN ? 1 : 0);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (bus.rd_ascii_o !== 8'(8'h30 + i) || bus.rd_valid_o !== 1'b1) begin
                n_err++;
                $display("FAIL pop_order[%0d]: asc=%h val=%b want %h/1",
                         i, bus.rd_ascii_o, bus.rd_valid_o, 8'(8'h30 + i));
            end
            cycle(1, 0, 0, 0, 1, 0, 0);
        end
        n_cmp++;
        if ({bus.empty_o, bus.rd_valid_o, bus.level_o} !== {1'b1, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL drained: emp=%b val=%b lvl=%0d want 1/0/0",
                     bus.empty_o, bus.rd_valid_o, bus.level_o);
        end
    endtask

    task automatic test_full_simul();
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            cycle(1, 1, 6'(i), 8'(8'h30 + i), 0, 0, 0);
        cycle(1, 1, 6'o55, 8'hAA, 1, 0, 0);
        n_cmp++;
        if ({bus.level_o, bus.rd_ascii_o, bus.overflow_o, bus.position_fifo_full_o}
            !== {5'd15, 8'h31, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL full_simul: lvl=%0d asc=%h ovf=%b full=%b want 15/31/1/0",
                     bus.level_o, bus.rd_ascii_o, bus.overflow_o,
                     bus.position_fifo_full_o);
        end
    endtask

    task automatic test_empty_simul();
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 6'o34, 8'h41, 1, 0, 0);
        n_cmp++;
        if ({bus.level_o, bus.underflow_o, bus.rd_position_o, bus.rd_ascii_o}
            !== {5'd1, 1'b1, 6'o34, 8'h41}) begin
            n_err++;
            $display("FAIL empty_simul: lvl=%0d udf=%b pos=%o asc=%h want 1/1/34/41",
                     bus.level_o, bus.underflow_o, bus.rd_position_o, bus.rd_ascii_o);
        end
    endtask

    task automatic test_threshold();
        bit seen;
        thr = 5'd4;
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 6'(i), 8'(i), 0, 0, 0);
        n_cmp++;
        if (bus.threshold_irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL irq_below: got %b want 0", bus.threshold_irq_o);
        end
        cycle(1, 1, 6'd3, 8'd3, 0, 0, 0);
        n_cmp++;
        if (bus.threshold_irq_o !== 1'b1) begin
            n_err++;
            $display("FAIL irq_at: got %b want 1", bus.threshold_irq_o);
        end
        cycle(1, 0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (bus.threshold_irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL irq_pop: got %b want 0", bus.threshold_irq_o);
        end
        thr = 5'd0;
        seen = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(1, 1, 6'(i), 8'(i), 0, 0, 0);
            if (bus.threshold_irq_o !== 1'b0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL irq_thr0: irq asserted want never");
        end
    endtask

    task automatic test_clear();
        thr = '0;
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 6'(i), 8'(8'h60 + i), 0, 0, 0);
        cycle(1, 1, 6'o11, 8'h99, 0, 1, 0);
        n_cmp++;
        if ({bus.level_o, bus.empty_o, bus.rd_valid_o, bus.underflow_o}
            !== {5'd0, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL clear: lvl=%0d emp=%b val=%b udf=%b want 0/1/0/1",
                     bus.level_o, bus.empty_o, bus.rd_valid_o, bus.underflow_o);
        end
        for (int i = 0; i < 17; i++) cycle(1, 1, 6'(i), 8'(i), 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 1);
        n_cmp++;
        if ({bus.overflow_o, bus.underflow_o, bus.drop_count_o} !== {2'b00, 8'd0}) begin
            n_err++;
            $display("FAIL ovf_clr: ovf=%b udf=%b drop=%0d want 0/0/0",
                     bus.overflow_o, bus.underflow_o, bus.drop_count_o);
        end
        cycle(1, 1, 0, 0, 0, 0, 1);
        n_cmp++;
        if (bus.overflow_o !== 1'b1 || int'(bus.drop_count_o) != (DROP_EN ? 1 : 0)) begin
            n_err++;
            $display("FAIL clr_vs_evt: ovf=%b drop=%0d want 1/%0d",
                     bus.overflow_o, bus.drop_count_o, DROP_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_midstream();
        thr = 5'd2;
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(1, 1, 6'(i), 8'(i), 0, 0, 0);
        cycle(0, 1, 6'o1, 8'h1, 0, 0, 0);
        n_cmp++;
        if ({bus.level_o, bus.empty_o, bus.rd_valid_o, bus.position_fifo_full_o,
             bus.threshold_irq_o, bus.overflow_o, bus.underflow_o}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: lvl=%0d emp=%b val=%b irq=%b udf=%b want 0/1/0/0/0",
                     bus.level_o, bus.empty_o, bus.rd_valid_o,
                     bus.threshold_irq_o, bus.underflow_o);
        end
    endtask

    task automatic test_random();
        logic [LW+14:0] got, exp;
        int wp, rp;
        bit w, r, c, oc, rn;
        thr = 5'd6;
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 900; i++) begin
            case ((i / 60) % 3)
                0:       begin wp = 85; rp = 20; end
                1:       begin wp = 20; rp = 80; end
                default: begin wp = 55; rp = 50; end
            endcase
            w  = $urandom_range(0, 99) < wp;
            r  = $urandom_range(0, 99) < rp;
            c  = $urandom_range(0, 99) < 2;
            oc = $urandom_range(0, 99) < 4;
            rn = $urandom_range(0, 299) != 0;
            if ($urandom_range(0, 29) == 0) thr = LW'($urandom_range(0, 17));
            cycle(rn, w, 6'($urandom), 8'($urandom), r, c, oc);
            got = {bus.level_o, bus.empty_o, bus.position_fifo_full_o,
                   bus.keycode_fifo_full_o, bus.rd_valid_o, bus.threshold_irq_o,
                   bus.overflow_o, bus.underflow_o, bus.drop_count_o};
            exp = {LW'(mq.size()), mq.size() == 0, mq.size() == DEPTH,
                   mq.size() == DEPTH, mq.size() != 0, m_irq,
                   m_ovf, m_udf, 8'(exp_drop())};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rand_status[%0d]: got %h want %h", i, got, exp);
            end
            if (mq.size() != 0) begin
                n_cmp++;
                if ({bus.rd_position_o, bus.rd_ascii_o} !== mq[0]) begin
                    n_err++;
                    $display("FAIL rand_head[%0d]: got %h want %h", i,
                             {bus.rd_position_o, bus.rd_ascii_o}, mq[0]);
                end
            end
        end
    endtask

    initial begin
        thr = '0;
        bus.threshold_i = '0;
        idle_inputs();
        test_reset();
        test_first_write();
        test_fill_overflow();
        test_full_simul();
        test_empty_simul();
        test_threshold();
        test_clear();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
